opcode_tag_alloc: RTL and testbench

Allocates and recycles 9-bit opcode tags (opcodeTagT) for the five opcode classes READ/WRITE/WAIT/EVICT/TRIM. It sits directly upstream of every consumer of opcodeTagT. It hands out tags encoded as OPCODEABASE_<type> + index and reclaims them when the command retires. Each type has its own free pool, so one class exhausting its tags never starves another.

---
 rtl/opcode_tag_alloc_pkg.sv | 32 +++
 rtl/opcode_tag_alloc_ffs.sv | 22 ++
 rtl/opcode_tag_alloc.sv | 140 ++++++++++++++
 tb/tb_opcode_tag_alloc.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/opcode_tag_alloc_pkg.sv
// Opcode tag types shared by the allocator and every consumer of opcodeTagT.
// A tag is the opcode class in the upper 3 bits and a per-class index in the lower 6.
package opcode_tag_alloc_pkg;

   localparam int OPCODE_TAG_INDEX_W = 6;
   localparam int OPCODE_TAG_TYPE_W  = 3;
   localparam int OPCODE_TAG_W       = OPCODE_TAG_TYPE_W + OPCODE_TAG_INDEX_W;

   typedef enum logic [OPCODE_TAG_TYPE_W-1:0] {
      OPCODE_READ  = 3'd0,
      OPCODE_WRITE = 3'd1,
      OPCODE_WAIT  = 3'd2,
      OPCODE_EVICT = 3'd3,
      OPCODE_TRIM  = 3'd4
   } opcodeEnumT;

   typedef logic [OPCODE_TAG_W-1:0]       opcodeTagT;
   typedef logic [OPCODE_TAG_INDEX_W-1:0] opcodeTagIndexT;

   // Each class owns a 64-entry window of the tag space.
   localparam opcodeTagT OPCODEABASE_READ  = 9'd0;
   localparam opcodeTagT OPCODEABASE_WRITE = 9'd64;
   localparam opcodeTagT OPCODEABASE_WAIT  = 9'd128;
   localparam opcodeTagT OPCODEABASE_EVICT = 9'd192;
   localparam opcodeTagT OPCODEABASE_TRIM  = 9'd256;

   // Concatenation equals OPCODEABASE_<op> + idx because the spacing is 64.
   function automatic opcodeTagT opcodeTagPack(input opcodeEnumT op, input opcodeTagIndexT idx);
      return {op, idx};
   endfunction

endpackage

// File: rtl/opcode_tag_alloc_ffs.sv
// Find-first-zero over a 64-bit allocation bitmap: lowest clear bit wins.
module opcode_tag_ffs
   import opcode_tag_alloc_pkg::*;
(
   input  logic [63:0]    i_vec,
   output opcodeTagIndexT o_idx,
   output logic           o_none
);

   // Scan downward so the last assignment left standing is the lowest zero.
   always_comb begin
      o_idx  = '0;
      o_none = 1'b1;
      for (int i = 63; i >= 0; i--) begin
         if (!i_vec[i]) begin
            o_idx  = opcodeTagIndexT'(i);
            o_none = 1'b0;
         end
      end
   end

endmodule

// File: rtl/opcode_tag_alloc.sv
// Per-class opcode tag allocator with one-cycle response latency.
// Optional free checking is enabled with OPCODE_TAG_ALLOC_CHECK_EN, which also
// adds the sticky err_free output.
module opcode_tag_alloc
   import opcode_tag_alloc_pkg::*;
#(
   parameter int TAGS_PER_TYPE = 64,
   parameter int NUM_TYPES     = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 alloc_valid,
   input  logic [2:0]           alloc_type,
   output logic                 alloc_ready,
   output logic                 rsp_valid,
   output opcodeTagT            rsp_tag,
   output logic                 rsp_err,
   input  logic                 free_valid,
   input  opcodeTagT            free_tag,
   output logic [NUM_TYPES-1:0] full_vec,
   output logic                 all_free,
   output logic [8:0]           outstanding
`ifdef OPCODE_TAG_ALLOC_CHECK_EN
   ,
   output logic                 err_free
`endif
);

   // Indices at or above TAGS_PER_TYPE are held permanently "allocated" so the
   // search and the full test work on a fixed 64-bit vector.
   localparam logic [63:0] PAD    = (TAGS_PER_TYPE >= 64) ? 64'd0 :
                                    ~((64'd1 << TAGS_PER_TYPE) - 64'd1);
   localparam logic [6:0]  TAGS_L = 7'(TAGS_PER_TYPE);
   localparam logic [2:0]  NT_L   = 3'(NUM_TYPES);

   logic [NUM_TYPES-1:0][63:0] r_bitmap, w_bitmap_nxt;
   logic [NUM_TYPES-1:0]       w_full_nxt;
   logic [8:0]                 r_outstanding, w_out_nxt;
   logic                       r_all_free;
   logic [63:0]                w_sel_vec;
   opcodeTagIndexT             w_ffs_idx;
   logic                       w_ffs_none;
   logic                       w_type_legal, w_hs, w_alloc_set;
   logic [2:0]                 w_ftype;
   opcodeTagIndexT             w_fidx;
   logic                       w_free_addr_ok, w_free_hit, w_free_clr;
`ifdef OPCODE_TAG_ALLOC_CHECK_EN
   logic                       r_err_free, w_free_bad;
`endif

   opcode_tag_ffs u_ffs (
      .i_vec  (w_sel_vec),
      .o_idx  (w_ffs_idx),
      .o_none (w_ffs_none)
   );

   // Request side: pick the requested pool and decide acceptance.
   always_comb begin
      w_type_legal = (alloc_type < NT_L);
      w_sel_vec    = '1;
      for (int t = 0; t < NUM_TYPES; t++) begin
         if (alloc_type == 3'(t)) w_sel_vec = r_bitmap[t];
      end
      alloc_ready = w_type_legal ? ~w_ffs_none : 1'b1;
      w_hs        = alloc_valid & alloc_ready;
      w_alloc_set = w_hs & w_type_legal;
   end

   // Release side: decode the tag and see whether it names a live allocation.
   always_comb begin
      w_ftype        = free_tag[8:6];
      w_fidx         = free_tag[5:0];
      w_free_addr_ok = (w_ftype < NT_L) && ({1'b0, w_fidx} < TAGS_L);
      w_free_hit     = 1'b0;
      for (int t = 0; t < NUM_TYPES; t++) begin
         if (w_ftype == 3'(t)) w_free_hit = r_bitmap[t][w_fidx];
      end
      w_free_hit = w_free_hit & w_free_addr_ok & free_valid;
`ifdef OPCODE_TAG_ALLOC_CHECK_EN
      w_free_clr = w_free_hit;
      w_free_bad = free_valid & ~w_free_hit;
`else
      w_free_clr = free_valid & w_free_addr_ok;
`endif
   end

   // Next bitmap: free clears first, alloc sets; both use pre-edge decisions.
   always_comb begin
      w_bitmap_nxt = r_bitmap;
      for (int t = 0; t < NUM_TYPES; t++) begin
         if (w_free_clr && (w_ftype == 3'(t)))     w_bitmap_nxt[t][w_fidx]    = 1'b0;
         if (w_alloc_set && (alloc_type == 3'(t))) w_bitmap_nxt[t][w_ffs_idx] = 1'b1;
         w_full_nxt[t] = &w_bitmap_nxt[t];
      end
      w_out_nxt = r_outstanding + 9'(w_alloc_set) - 9'(w_free_hit);
   end

   // Pool state and registered status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bitmap      <= {NUM_TYPES{PAD}};
         r_outstanding <= '0;
         r_all_free    <= 1'b1;
         full_vec      <= '0;
      end else begin
         r_bitmap      <= w_bitmap_nxt;
         r_outstanding <= w_out_nxt;
         r_all_free    <= (w_out_nxt == 9'd0);
         full_vec      <= w_full_nxt;
      end
   end

   // Response register: pulse on handshake, tag and error hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_tag   <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= w_hs;
         if (w_hs) begin
            rsp_tag <= w_type_legal ? opcodeTagPack(opcodeEnumT'(alloc_type), w_ffs_idx) : '0;
            rsp_err <= ~w_type_legal;
         end
      end
   end

`ifdef OPCODE_TAG_ALLOC_CHECK_EN
   // Sticky flag for frees that named no live allocation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          r_err_free <= 1'b0;
      else if (w_free_bad) r_err_free <= 1'b1;
   end
   assign err_free = r_err_free;
`endif

   assign outstanding = r_outstanding;
   assign all_free    = r_all_free;

endmodule

// File: tb/tb_opcode_tag_alloc.sv
// Randomized and directed bench for opcode_tag_alloc against a pool-level model.
module tb_opcode_tag_alloc;

   localparam int TAGS = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       alloc_valid = 1'b0;
   logic [2:0] alloc_type = '0;
   logic       alloc_ready;
   logic       rsp_valid;
   logic [8:0] rsp_tag;
   logic       rsp_err;
   logic       free_valid = 1'b0;
   logic [8:0] free_tag = '0;
   logic [4:0] full_vec;
   logic       all_free;
   logic [8:0] outstanding;
`ifdef OPCODE_TAG_ALLOC_CHECK_EN
   logic       err_free;
`endif

   opcode_tag_alloc #(.TAGS_PER_TYPE(TAGS), .NUM_TYPES(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_valid(alloc_valid), .alloc_type(alloc_type), .alloc_ready(alloc_ready),
      .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
      .free_valid(free_valid), .free_tag(free_tag),
      .full_vec(full_vec), .all_free(all_free), .outstanding(outstanding)
`ifdef OPCODE_TAG_ALLOC_CHECK_EN
      , .err_free(err_free)
`endif
   );

   always #5 clk = ~clk;

   // Model: which tags of each class are held, plus the expected response.
   bit mdl [5][TAGS];
   int mcnt;
   bit m_rv, m_err, m_errfree;
   int m_tag;
   bit started;
   int n_chk, n_err;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_first(input int t);
      for (int i = 0; i < TAGS; i++) if (!mdl[t][i]) return i;
      return -1;
   endfunction

   function automatic bit m_ready(input int t);
      if (t > 4) return 1'b1;
      return m_first(t) >= 0;
   endfunction

   task automatic m_clear();
      for (int t = 0; t < 5; t++) for (int i = 0; i < TAGS; i++) mdl[t][i] = 1'b0;
      mcnt = 0; m_rv = 0; m_err = 0; m_tag = 0; m_errfree = 0;
   endtask

   // Apply one clock edge of the rules to the model using the pre-edge pools.
   task automatic m_step();
      int t, idx, ft, ftyp, fix;
      bit hs, legal, hit;
      t   = int'(alloc_type);
      hs  = alloc_valid && m_ready(t);
      idx = (t < 5) ? m_first(t) : 0;
      ft   = int'(free_tag);
      ftyp = ft / 64;
      fix  = ft % 64;
      legal = (ftyp < 5) && (fix < TAGS);
      hit   = legal && mdl[ftyp][fix];
      if (free_valid) begin
`ifdef OPCODE_TAG_ALLOC_CHECK_EN
         if (hit) begin mdl[ftyp][fix] = 1'b0; mcnt--; end
         else m_errfree = 1'b1;
`else
         if (legal) begin
            if (hit) mcnt--;
            mdl[ftyp][fix] = 1'b0;
         end
`endif
      end
      if (hs && t < 5) begin mdl[t][idx] = 1'b1; mcnt++; end
      m_rv = hs;
      if (hs) begin
         m_tag = (t < 5) ? t * 64 + idx : 0;
         m_err = (t > 4);
      end
   endtask

   // Compare process: every falling edge, all outputs against the model.
   always @(negedge clk) begin
      if (started) begin
         chk("alloc_ready", int'(alloc_ready), int'(m_ready(int'(alloc_type))));
         for (int t = 0; t < 5; t++) chk("full_vec", int'(full_vec[t]), int'(m_first(t) < 0));
         chk("all_free", int'(all_free), int'(mcnt == 0));
         chk("outstanding", int'(outstanding), mcnt);
         chk("rsp_valid", int'(rsp_valid), int'(m_rv));
         if (m_rv) begin
            chk("rsp_tag", int'(rsp_tag), m_tag);
            chk("rsp_err", int'(rsp_err), int'(m_err));
         end
`ifdef OPCODE_TAG_ALLOC_CHECK_EN
         chk("err_free", int'(err_free), int'(m_errfree));
`endif
      end
   end

   task automatic drive(input bit av, input int at, input bit fv, input int ft);
      alloc_valid = av; alloc_type = 3'(at); free_valid = fv; free_tag = 9'(ft);
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) m_step();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_clear();
      drive(0, 0, 0, 0);
      tick(); tick();
      rst_n = 1'b1;
   endtask

   initial begin
      n_chk = 0; n_err = 0; started = 0;
      m_clear();
      #1;
      started = 1;
      do_reset();
      chk("reset_out", int'(outstanding), 0);
      chk("reset_all_free", int'(all_free), 1);
      chk("reset_rsp", int'({rsp_valid, rsp_err, rsp_tag}), 0);

      // READ, WRITE, TRIM back to back.
      drive(1, 0, 0, 0); tick(); chk("lit_read", int'(rsp_tag), 0);
      drive(1, 1, 0, 0); tick(); chk("lit_write", int'(rsp_tag), 64);
      drive(1, 4, 0, 0); tick(); chk("lit_trim", int'(rsp_tag), 256);
      drive(0, 0, 0, 0); tick();
      chk("lit_out3", int'(outstanding), 3);
      chk("lit_busy", int'(all_free), 0);

      // Fill the WAIT pool.
      for (int i = 0; i < TAGS; i++) begin
         drive(1, 2, 0, 0); tick();
         chk("lit_wait_tag", int'(rsp_tag), 128 + i);
      end
      drive(1, 2, 0, 0); #1;
      chk("lit_wait_full_rdy", int'(alloc_ready), 0);
      chk("lit_wait_full_vec", int'(full_vec[2]), 1);
      drive(1, 3, 0, 0); tick(); chk("lit_evict", int'(rsp_tag), 192);

      // A free does not make room in its own cycle.
      drive(1, 2, 1, 150); #1;
      chk("lit_same_cycle_rdy", int'(alloc_ready), 0);
      tick();
      chk("lit_no_rsp", int'(rsp_valid), 0);
      drive(1, 2, 0, 0); tick(); chk("lit_refill", int'(rsp_tag), 150);

      // Illegal class.
      drive(1, 6, 0, 0); #1;
      chk("lit_bad_rdy", int'(alloc_ready), 1);
      tick();
      chk("lit_bad_rsp", int'({rsp_valid, rsp_err}), 3);
      chk("lit_bad_tag", int'(rsp_tag), 0);
      chk("lit_bad_out", int'(outstanding), 3 + 64 + 1);

      // Double free of WRITE index 1.
      drive(1, 1, 0, 0); tick(); chk("lit_w65", int'(rsp_tag), 65);
      drive(0, 0, 1, 65); tick();
      chk("lit_free65", int'(outstanding), 69 - 1 + 1 - 1);
      drive(0, 0, 1, 65); tick();
      chk("lit_free65b", int'(outstanding), 68);
`ifdef OPCODE_TAG_ALLOC_CHECK_EN
      chk("lit_err_dbl", int'(err_free), 1);
      do_reset();
      drive(0, 0, 1, 320); tick();
      chk("lit_err_320", int'(err_free), 1);
`endif

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         int at, ft;
         at = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
         if ($urandom_range(0, 3) == 0) ft = $urandom_range(0, 511);
         else ft = $urandom_range(0, 4) * 64 + $urandom_range(0, 15);
         drive($urandom_range(0, 2) != 0, at, $urandom_range(0, 1) == 1, ft);
         tick();
      end

      // Reset mid-burst discards everything.
      do_reset();
      for (int i = 0; i < 10; i++) begin drive(1, 0, 0, 0); tick(); end
      drive(1, 0, 0, 0);
      rst_n = 1'b0;
      m_clear();
      tick();
      chk("lit_rst_free", int'(all_free), 1);
      chk("lit_rst_out", int'(outstanding), 0);
      chk("lit_rst_rsp", int'(rsp_valid), 0);
      rst_n = 1'b1;
      drive(1, 0, 0, 0); tick();
      chk("lit_after_rst", int'(rsp_tag), 0);
      drive(0, 0, 0, 0); tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
